// File: rtl/led_blink_multi.sv
// led_blink_multi: NUM_CH independent LED channels clocked from clk100.
// Each channel can be OFF, ON, BLINK (50% duty) or ONESHOT (one timed high
// pulse followed by a done_o strobe). Channels are programmed through a
// single-cycle write port. sync_i realigns the phase of every blinking channel.
module led_blink_multi #(
    parameter int          NUM_CH   = 4,
    parameter int          CLK_HZ   = 100_000_000,
    parameter int          MAX_DIV  = 20,
    parameter logic [1:0]  RST_MODE = 2'b10,
    parameter logic [4:0]  RST_DIV  = 5'd4,
    localparam int         CNT_W    = $clog2(CLK_HZ + 1),
    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [1:0]        wr_mode_i,
    input  logic [4:0]        wr_div_i,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] led_o,
    output logic [NUM_CH-1:0] done_o
);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_ONESHOT = 2'b11
    } mode_t;

    // Terminal count for a divider value. Out-of-range dividers (0 or above
    // MAX_DIV) fall back to the slowest rate rather than being rejected.
    function automatic logic [CNT_W-1:0] calc_cnt_max(input logic [4:0] d);
        logic [31:0] q;
        if ((d == 5'd0) || (32'(d) > 32'(MAX_DIV))) begin
            q = 32'(CLK_HZ);
        end else begin
            q = 32'(CLK_HZ) / 32'(d);
        end
        return CNT_W'(q);
    endfunction

    mode_t            mode_r    [NUM_CH];
    logic [CNT_W-1:0] cnt_r     [NUM_CH];
    logic [CNT_W-1:0] cnt_max_r [NUM_CH];
    logic [CNT_W-1:0] wr_cnt_max;

    // The division only happens on the write path; the stored terminal count
    // keeps the per-cycle counter compare divider-free.
    always_comb begin
        wr_cnt_max = calc_cnt_max(wr_div_i);
    end

    // Per-channel mode sequencing. Priority: reset, write to this channel,
    // sync (BLINK channels only), then the mode's own counting behaviour.
    // An out-of-range wr_ch_i matches no channel, so it changes nothing.
    always_ff @(posedge clk100) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mode_r[ch]    <= mode_t'(RST_MODE);
                cnt_r[ch]     <= '0;
                cnt_max_r[ch] <= calc_cnt_max(RST_DIV);
                led_o[ch]     <= 1'b0;
                done_o[ch]    <= 1'b0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                done_o[ch] <= 1'b0;
                if (wr_en_i && (wr_ch_i == CH_W'(ch))) begin
                    // A write aborts any shot in flight without a done pulse.
                    mode_r[ch]    <= mode_t'(wr_mode_i);
                    cnt_r[ch]     <= '0;
                    cnt_max_r[ch] <= wr_cnt_max;
                    led_o[ch]     <= (mode_t'(wr_mode_i) != M_OFF);
                end else if (sync_i && (mode_r[ch] == M_BLINK)) begin
                    cnt_r[ch] <= '0;
                    led_o[ch] <= 1'b1;
                end else begin
                    case (mode_r[ch])
                        M_OFF: begin
                            cnt_r[ch] <= '0;
                            led_o[ch] <= 1'b0;
                        end
                        M_ON: begin
                            cnt_r[ch] <= '0;
                            led_o[ch] <= 1'b1;
                        end
                        M_BLINK: begin
                            if (cnt_r[ch] == cnt_max_r[ch]) begin
                                cnt_r[ch] <= '0;
                                led_o[ch] <= ~led_o[ch];
                            end else begin
                                cnt_r[ch] <= cnt_r[ch] + CNT_W'(1);
                            end
                        end
                        default: begin
                            // ONESHOT: hold high until terminal count, then
                            // drop, strobe done and fall back to OFF.
                            if (cnt_r[ch] == cnt_max_r[ch]) begin
                                cnt_r[ch]  <= '0;
                                led_o[ch]  <= 1'b0;
                                mode_r[ch] <= M_OFF;
                                done_o[ch] <= 1'b1;
                            end else begin
                                cnt_r[ch] <= cnt_r[ch] + CNT_W'(1);
                                led_o[ch] <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
